// File: rtl/parking_request_sequencer_if.sv
// Signal bundle between the gate logic, the request sequencer and parking_lot_top.
// req_*: a request transfers on a rising edge where req_valid and req_ready are both high; the gate may change or drop req_* freely otherwise.
interface parking_request_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_plate;
  logic        req_out;
  logic        lot_idle;
  logic        lot_full;
  logic        leakage;
  logic [15:0] license_plate;
  logic        in_mode;
  logic        out_mode;

  modport master (
    output req_valid, req_plate, req_out, lot_idle, lot_full, leakage,
    input  req_ready, license_plate, in_mode, out_mode
  );

  modport slave (
    input  req_valid, req_plate, req_out, lot_idle, lot_full, leakage,
    output req_ready, license_plate, in_mode, out_mode
  );
endinterface

// File: rtl/parking_request_sequencer.sv
// Queues gate entry/exit requests and issues them one at a time to parking_lot_top
// as single-cycle mode pulses, dropping requests that cannot be served.
module parking_request_sequencer #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  parking_request_sequencer_if.slave    bus,
  output logic [3:0]                    pending,
  output logic                          busy,
  output logic                          rej_pulse,
  output logic [1:0]                    rej_code,
  output logic [7:0]                    issued_cnt,
  output logic [1:0]                    dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [16:0]     mem_q [DEPTH];
  logic [16:0]     mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            req_ready_q, req_ready_d;
  logic [15:0]     plate_q, plate_d;
  logic            in_mode_q, in_mode_d;
  logic            out_mode_q, out_mode_d;
  logic            busy_q, busy_d;
  logic            rej_pulse_q, rej_pulse_d;
  logic [1:0]      rej_code_q, rej_code_d;
  logic [7:0]      issued_q, issued_d;

  logic [16:0]     head;
  logic            bcd_ok;
  logic            accept;
  logic            push;
  logic            pop;
  logic            fsm_rej;
  logic [1:0]      fsm_code;

  // Entry layout: bit 16 is direction (1 = exit), bits 15:0 the BCD plate.
  assign head   = mem_q[rd_ptr_q];
  assign bcd_ok = (bus.req_plate[15:12] <= 4'd9) && (bus.req_plate[11:8] <= 4'd9) &&
                  (bus.req_plate[7:4]   <= 4'd9) && (bus.req_plate[3:0]  <= 4'd9);
  assign accept = bus.req_valid && req_ready_q;
  assign push   = accept && bcd_ok;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issued_d   = issued_q;
    plate_d    = 16'h0000;
    in_mode_d  = 1'b0;
    out_mode_d = 1'b0;
    pop        = 1'b0;
    fsm_rej    = 1'b0;
    fsm_code   = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if ((count_q != 4'd0) && bus.lot_idle && !bus.leakage) begin
          if (!head[16] && bus.lot_full) begin
            pop      = 1'b1;
            fsm_rej  = 1'b1;
            fsm_code = 2'b10;
          end else begin
            // Pulse outputs are loaded here so they are high during the ISSUE cycle.
            state_d    = S_ISSUE;
            plate_d    = head[15:0];
            in_mode_d  = !head[16];
            out_mode_d = head[16];
          end
        end
      end
      S_ISSUE: begin
        pop     = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!bus.lot_idle) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          fsm_rej  = 1'b1;
          fsm_code = 2'b11;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (bus.lot_idle) begin
          issued_d = issued_q + 8'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rej_pulse_d = 1'b0;
    rej_code_d  = rej_code_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.req_out, bus.req_plate};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    // A bad-BCD reject on the same edge as an FSM drop takes the flag; the drop still happens.
    if (accept && !bcd_ok) begin
      rej_pulse_d = 1'b1;
      rej_code_d  = 2'b01;
    end else if (fsm_rej) begin
      rej_pulse_d = 1'b1;
      rej_code_d  = fsm_code;
    end
    req_ready_d = (count_d != 4'(DEPTH));
    busy_d      = (state_d != S_IDLE) || (count_d != 4'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 4'd0;
      req_ready_q <= 1'b1;
      plate_q     <= 16'h0000;
      in_mode_q   <= 1'b0;
      out_mode_q  <= 1'b0;
      busy_q      <= 1'b0;
      rej_pulse_q <= 1'b0;
      rej_code_q  <= 2'b00;
      issued_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      plate_q     <= plate_d;
      in_mode_q   <= in_mode_d;
      out_mode_q  <= out_mode_d;
      busy_q      <= busy_d;
      rej_pulse_q <= rej_pulse_d;
      rej_code_q  <= rej_code_d;
      issued_q    <= issued_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.license_plate = plate_q;
  assign bus.in_mode       = in_mode_q;
  assign bus.out_mode      = out_mode_q;
  assign pending           = count_q;
  assign busy              = busy_q;
  assign rej_pulse         = rej_pulse_q;
  assign rej_code          = rej_code_q;
  assign issued_cnt        = issued_q;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_parking_request_sequencer.sv
// Bench for parking_request_sequencer: issued requests are pushed to exp_q when driven
// and popped by a monitor when a mode pulse appears; a small lot model acknowledges pulses.
module tb_parking_request_sequencer;
  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 4;
  localparam logic [36:0] RST_SNAP = {16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 8'd0, 1'b1, 2'd0};

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  pending;
  logic        busy;
  logic        rej_pulse;
  logic [1:0]  rej_code;
  logic [7:0]  issued_cnt;
  logic [1:0]  dbg_state;

  logic        lot_auto;
  logic        lot_idle_man;
  int          lot_timer = 0;
  int          cyc = 0;
  int          last_pulse = -10;
  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_exp;
  logic [16:0] mon_got;

  parking_request_sequencer_if bus();

  parking_request_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .pending    (pending),
    .busy       (busy),
    .rej_pulse  (rej_pulse),
    .rej_code   (rej_code),
    .issued_cnt (issued_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Lot model: leaves idle one cycle after a pulse, stays busy for 5 cycles.
  always @(negedge clock) begin
    if (bus.in_mode || bus.out_mode) lot_timer = 6;
    else if (lot_timer > 0) lot_timer = lot_timer - 1;
  end
  assign bus.lot_idle = lot_auto ? ((lot_timer == 0) || (lot_timer == 6)) : lot_idle_man;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (bus.in_mode || bus.out_mode) begin
      checks++;
      if (bus.in_mode === bus.out_mode) begin
        errors++; $display("FAIL mode_exclusive: in=%0b out=%0b expected only one high", bus.in_mode, bus.out_mode);
      end
      checks++;
      if (cyc - last_pulse < 3) begin
        errors++; $display("FAIL pulse_spacing: got %0d cycles expected >= 3", cyc - last_pulse);
      end
      last_pulse = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_pulse: plate %h dir %0b with empty expected queue", bus.license_plate, bus.out_mode);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = {bus.out_mode, bus.license_plate};
        if (mon_got !== mon_exp) begin
          errors++; $display("FAIL issue_order: got %h expected %h", mon_got, mon_exp);
        end
      end
    end else begin
      checks++;
      if (bus.license_plate !== 16'h0000) begin
        errors++; $display("FAIL plate_idle: got %h expected 0000", bus.license_plate);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [36:0] snapshot();
    return {bus.license_plate, bus.in_mode, bus.out_mode, pending, busy, rej_pulse, rej_code,
            issued_cnt, bus.req_ready, dbg_state};
  endfunction

  task automatic push_req(input logic [15:0] plate, input logic dir, input bit expect_issue);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clock); n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL push_ready_timeout: req_ready=%0b expected 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_plate = plate;
    bus.req_out   = dir;
    if (expect_issue) exp_q.push_back({dir, plate});
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || dbg_state !== 2'd0) && n < budget) begin
      @(negedge clock); n++;
    end
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL idle_timeout: busy=%0b state=%0d expected 0/0", busy, dbg_state);
    end
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget);
    int n = 0;
    while (dbg_state !== target && n < budget) begin
      @(negedge clock); n++;
    end
    checks++;
    if (dbg_state !== target) begin
      errors++; $display("FAIL state_timeout: state=%0d expected %0d", dbg_state, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (snapshot() !== RST_SNAP) begin
      errors++; $display("FAIL reset_values: got %h expected %h", snapshot(), RST_SNAP);
    end
  endtask

  task automatic test_single_entry();
    lot_auto = 1'b1;
    push_req(16'h9423, 1'b0, 1'b1);
    checks++;
    if (bus.in_mode !== 1'b0 || pending !== 4'd1) begin
      errors++; $display("FAIL single_accept: in_mode=%0b pending=%0d expected 0/1", bus.in_mode, pending);
    end
    @(negedge clock);
    checks++;
    if (bus.in_mode !== 1'b1 || bus.license_plate !== 16'h9423) begin
      errors++; $display("FAIL single_latency: in_mode=%0b plate=%h expected 1/9423", bus.in_mode, bus.license_plate);
    end
    wait_idle(50);
    checks++;
    if (issued_cnt !== 8'd1) begin
      errors++; $display("FAIL single_issued: got %0d expected 1", issued_cnt);
    end
  endtask

  task automatic test_back_to_back();
    push_req(16'h8754, 1'b0, 1'b1);
    push_req(16'h8754, 1'b1, 1'b1);
    checks++;
    if (pending !== 4'd2) begin
      errors++; $display("FAIL b2b_pending2: got %0d expected 2", pending);
    end
    @(negedge clock);
    checks++;
    if (pending !== 4'd1) begin
      errors++; $display("FAIL b2b_pending1: got %0d expected 1", pending);
    end
    wait_idle(100);
    checks++;
    if (pending !== 4'd0 || issued_cnt !== 8'd3 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_done: pending=%0d issued=%0d left=%0d expected 0/3/0", pending, issued_cnt, exp_q.size());
    end
  endtask

  task automatic test_bad_bcd();
    push_req(16'h9A23, 1'b0, 1'b0);
    checks++;
    if (rej_pulse !== 1'b1 || rej_code !== 2'b01 || pending !== 4'd0) begin
      errors++; $display("FAIL bcd_reject: pulse=%0b code=%b pending=%0d expected 1/01/0", rej_pulse, rej_code, pending);
    end
    @(negedge clock);
    checks++;
    if (rej_pulse !== 1'b0 || rej_code !== 2'b01) begin
      errors++; $display("FAIL bcd_hold: pulse=%0b code=%b expected 0/01", rej_pulse, rej_code);
    end
  endtask

  task automatic test_lot_full();
    bus.lot_full = 1'b1;
    push_req(16'h1234, 1'b0, 1'b0);
    push_req(16'h5678, 1'b1, 1'b1);
    checks++;
    if (rej_pulse !== 1'b1 || rej_code !== 2'b10 || pending !== 4'd1) begin
      errors++; $display("FAIL full_reject: pulse=%0b code=%b pending=%0d expected 1/10/1", rej_pulse, rej_code, pending);
    end
    wait_idle(100);
    checks++;
    if (issued_cnt !== 8'd4 || exp_q.size() != 0) begin
      errors++; $display("FAIL full_exit_issue: issued=%0d left=%0d expected 4/0", issued_cnt, exp_q.size());
    end
    bus.lot_full = 1'b0;
  endtask

  task automatic test_ack_timeout();
    lot_auto = 1'b0;
    lot_idle_man = 1'b1;
    push_req(16'h1111, 1'b0, 1'b1);
    wait_state(2'd2, 20);
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
      @(negedge clock);
      checks++;
      if (dbg_state !== 2'd2 || rej_pulse !== 1'b0) begin
        errors++; $display("FAIL ack_wait_%0d: state=%0d pulse=%0b expected 2/0", i, dbg_state, rej_pulse);
      end
    end
    @(negedge clock);
    checks++;
    if (rej_pulse !== 1'b1 || rej_code !== 2'b11 || dbg_state !== 2'd0 || issued_cnt !== 8'd4) begin
      errors++; $display("FAIL ack_timeout: pulse=%0b code=%b state=%0d issued=%0d expected 1/11/0/4",
                         rej_pulse, rej_code, dbg_state, issued_cnt);
    end
    lot_auto = 1'b1;
  endtask

  task automatic test_leakage_fill();
    bus.leakage = 1'b1;
    push_req(16'h0001, 1'b0, 1'b1);
    push_req(16'h0002, 1'b1, 1'b1);
    push_req(16'h0003, 1'b0, 1'b1);
    push_req(16'h0004, 1'b1, 1'b1);
    checks++;
    if (pending !== 4'd4 || bus.req_ready !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL leak_full: pending=%0d ready=%0b state=%0d expected 4/0/0", pending, bus.req_ready, dbg_state);
    end
    bus.req_valid = 1'b1;
    bus.req_plate = 16'h5555;
    bus.req_out   = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b0;
    checks++;
    if (pending !== 4'd4 || rej_pulse !== 1'b0) begin
      errors++; $display("FAIL full_ignore: pending=%0d pulse=%0b expected 4/0", pending, rej_pulse);
    end
    bus.leakage = 1'b0;
    wait_idle(200);
    checks++;
    if (issued_cnt !== 8'd8 || exp_q.size() != 0) begin
      errors++; $display("FAIL leak_drain: issued=%0d left=%0d expected 8/0", issued_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    push_req(16'h7777, 1'b0, 1'b1);
    push_req(16'h6666, 1'b0, 1'b0);
    wait_state(2'd3, 20);
    checks++;
    if (pending !== 4'd1) begin
      errors++; $display("FAIL mid_pending: got %0d expected 1", pending);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (snapshot() !== RST_SNAP) begin
      errors++; $display("FAIL mid_reset_values: got %h expected %h", snapshot(), RST_SNAP);
    end
    reset = 1'b0;
    repeat (8) @(negedge clock);
    checks++;
    if (pending !== 4'd0 || issued_cnt !== 8'd0 || exp_q.size() != 0) begin
      errors++; $display("FAIL mid_flush: pending=%0d issued=%0d left=%0d expected 0/0/0", pending, issued_cnt, exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_plate = 16'h0000;
    bus.req_out   = 1'b0;
    bus.lot_full  = 1'b0;
    bus.leakage   = 1'b0;
    lot_auto      = 1'b0;
    lot_idle_man  = 1'b1;
    test_reset();
    test_single_entry();
    test_back_to_back();
    test_bad_bcd();
    test_lot_full();
    test_ack_timeout();
    test_leakage_fill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/parking_request_sequencer.md
Name: parking_request_sequencer

Overview:
- Request-side initiator for parking_lot_top. Produces the `license_plate` / `in_mode` / `out_mode` stimulus that parking_lot_top consumes as a responder.
- Accepts car entry/exit events from gate logic into a small FIFO.
- Issues each event to the lot as a one-cycle mode pulse, only while the lot is idle and no leakage is present.
- Waits for the lot to complete the request before issuing the next; rejects requests that cannot be served.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..8.
- ACK_TIMEOUT, 4, cycles to wait for `lot_idle` to fall after a pulse before declaring no-ack.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  gate presents a request this cycle.
- req_ready  out  1  FIFO can accept; equals !full.
- req_plate  in  16  plate as four BCD digits, [15:12] most significant.
- req_out  in  1  0 = entry, 1 = exit.
- lot_idle  in  1  high while parking_lot_top is in its idle state.
- lot_full  in  1  lot has no free slot for entry.
- leakage  in  1  leakage alarm; blocks new issues.
- license_plate  out  16  plate to the lot; 16'h0000 when not issuing.
- in_mode  out  1  one-cycle entry pulse.
- out_mode  out  1  one-cycle exit pulse.
- pending  out  4  FIFO occupancy, 0..DEPTH.
- busy  out  1  state != IDLE or pending != 0.
- rej_pulse  out  1  one-cycle flag: a request was dropped.
- rej_code  out  2  01 invalid BCD, 10 lot full, 11 no-ack timeout; holds last code.
- issued_cnt  out  8  completed requests, wraps 255 -> 0.

Behaviour:
- All outputs are registered.
- Reset values:
  - `license_plate` = 0, `in_mode` = 0, `out_mode` = 0.
  - `pending` = 0, `busy` = 0.
  - `rej_pulse` = 0, `rej_code` = 00.
  - `issued_cnt` = 0.
  - `req_ready` = 1 in the cycle after reset deasserts.
- Reset mid-operation: flushes the FIFO, abandons any in-flight request and returns the FSM to IDLE. No pulse is emitted during reset.
- Enqueue (on the edge where `req_valid` & `req_ready` are high):
  - If any nibble of `req_plate` is > 9: not enqueued; `rej_pulse` = 1 with `rej_code` = 01 in the next cycle.
  - Otherwise {`req_out`, `req_plate`} is pushed.
- Full FIFO: `req_ready` = 0. A request presented while full is ignored with no reject, even if a pop occurs on the same edge.
- Simultaneous push and pop when not full: both happen; `pending` is unchanged.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Advances when `pending` > 0, `lot_idle` = 1 and `leakage` = 0.
  - Head is an entry and `lot_full` = 1: pop, `rej_pulse` with code 10, stay in IDLE. Next head is evaluated on the following cycle.
  - Otherwise: go to ISSUE.
- ISSUE (exactly one cycle):
  - `license_plate` = head plate; `in_mode` = !dir, `out_mode` = dir; pop head.
  - Next state: WAIT_ACK; timeout counter cleared.
- WAIT_ACK:
  - `lot_idle` = 0: go to WAIT_DONE.
  - Else counter increments. After ACK_TIMEOUT cycles without `lot_idle` falling: `rej_pulse` with code 11, go to IDLE.
- WAIT_DONE:
  - `lot_idle` = 1: `issued_cnt` += 1, go to IDLE.
  - No timeout in this state.
- `leakage` asserted in WAIT_ACK or WAIT_DONE does not abort the in-flight request; it only blocks leaving IDLE.
- Latency: request accepted on edge N, with `lot_idle` = 1 and no leakage → mode pulse is high between edges N+1 and N+2.
- Minimum spacing between two issues: 3 cycles.
- `in_mode` and `out_mode` are never high together and never high for two consecutive cycles.
- `rej_pulse` from an enqueue reject and from an IDLE/WAIT_ACK reject on the same edge: the enqueue reject (code 01) wins; the other drop is still performed.

Test Plan:
- Reset, then enqueue entry 9423 with `lot_idle` = 1. Lot model drops `lot_idle` 1 cycle after the pulse and raises it 5 cycles later → `in_mode` high for one cycle with `license_plate` = 16'h9423; `issued_cnt` = 1; `busy` = 0 afterwards.
- Enqueue entry 8754 then exit 8754 back-to-back → two pulses, `in_mode` then `out_mode`, separated by the lot busy window; `pending` goes 2, 1, 0.
- Enqueue plate 16'h9A23 → not queued, `rej_pulse` = 1, `rej_code` = 01, `pending` stays 0.
- Hold `lot_full` = 1 and enqueue entry 1234 then exit 5678 → 1234 rejected with code 10; 5678 issued with `out_mode`.
- Hold `lot_idle` = 1 forever after the pulse → `rej_code` = 11 exactly ACK_TIMEOUT cycles after WAIT_ACK entry; FSM back in IDLE.
- Fill FIFO to DEPTH with `leakage` = 1 → `req_ready` = 0, no pulses; deassert `leakage` → all 4 issued in order. Assert `reset` mid-WAIT_DONE → all outputs return to their reset values on the next edge.
